// File: rtl/rfa_pkg.sv
// Shared types and default widths for the register-file access sequencer.
package rfa_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;

  typedef enum logic [1:0] {
    OP_MOV  = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_READ = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_SRC   = 3'd1,
    ST_RD_DST   = 3'd2,
    ST_WR_SETUP = 3'd3,
    ST_WR_PULSE = 3'd4,
    ST_RESP     = 3'd5
  } state_e;

endpackage

// File: rtl/rfa_alu.sv
// Combinational ALU: a is the destination value, b the source value.
module rfa_alu import rfa_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum    = '0;
    result = b;
    carry  = 1'b0;
    if (op == OP_ADD) begin
      sum    = {1'b0, a} + {1'b0, b};
      result = sum[DATA_W-1:0];
      carry  = sum[DATA_W];
    end else if (op == OP_SUB) begin
      // Borrow is reported as dst < src rather than the raw extended bit.
      sum    = {1'b0, a} - {1'b0, b};
      result = sum[DATA_W-1:0];
      carry  = (a < b);
    end
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rfile_access_ctrl.sv
// Sequencer driving a single-address register file: read source, read destination,
// compute, write back with a one-cycle strobe, then return the result.
module rfile_access_ctrl import rfa_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_src,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_zero,
  output logic              resp_carry,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_we,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [2:0]        state_dbg
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready;
  // cmd_ready is high only in IDLE, resp_valid only in RESP.

  state_e            state;
  op_e               op_q;
  logic [ADDR_W-1:0] dst_q;
  logic [DATA_W-1:0] opa_q;
  logic              carry_q;
  logic              zero_q;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;

  rfa_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (rf_rdata),
    .b      (opa_q),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  assign cmd_ready = (state == ST_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_q       <= OP_MOV;
      dst_q      <= '0;
      opa_q      <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      rf_addr    <= '0;
      rf_wdata   <= '0;
      rf_we      <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_zero  <= 1'b0;
      resp_carry <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q    <= op_e'(cmd_op);
            dst_q   <= cmd_dst;
            rf_addr <= cmd_src;
            carry_q <= 1'b0;
            state   <= ST_RD_SRC;
          end
        end
        ST_RD_SRC: begin
          opa_q <= rf_rdata;
          case (op_q)
            OP_READ: begin
              resp_data  <= rf_rdata;
              resp_zero  <= (rf_rdata == '0);
              resp_carry <= 1'b0;
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end
            OP_MOV: begin
              rf_wdata <= rf_rdata;
              zero_q   <= (rf_rdata == '0);
              rf_addr  <= dst_q;
              state    <= ST_WR_SETUP;
            end
            default: begin
              rf_addr <= dst_q;
              state   <= ST_RD_DST;
            end
          endcase
        end
        ST_RD_DST: begin
          rf_wdata <= alu_result;
          carry_q  <= alu_carry;
          zero_q   <= alu_zero;
          state    <= ST_WR_SETUP;
        end
        ST_WR_SETUP: begin
          rf_we <= 1'b1;
          state <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          rf_we      <= 1'b0;
          resp_data  <= rf_wdata;
          resp_zero  <= zero_q;
          resp_carry <= carry_q;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rfile_access_ctrl.sv
// Bench for rfile_access_ctrl with a behavioural 4x8 register file and a reference model.
module tb_rfile_access_ctrl;
  import rfa_pkg::*;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [1:0]    cmd_dst = 2'd0;
  logic [1:0]    cmd_src = 2'd0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_data;
  logic          resp_zero;
  logic          resp_carry;
  logic [1:0]    rf_addr;
  logic [DW-1:0] rf_wdata;
  logic          rf_we;
  logic [DW-1:0] rf_rdata;
  logic [2:0]    state_dbg;

  rfile_access_ctrl #(.DATA_W(DW), .ADDR_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_dst    (cmd_dst),
    .cmd_src    (cmd_src),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_zero  (resp_zero),
    .resp_carry (resp_carry),
    .rf_addr    (rf_addr),
    .rf_wdata   (rf_wdata),
    .rf_we      (rf_we),
    .rf_rdata   (rf_rdata),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  // Behavioural register file: combinational read, write on rising rf_we.
  logic [DW-1:0] rf_mem [4];
  logic [DW-1:0] preload_val [4];
  logic          do_load = 1'b0;
  assign rf_rdata = rf_mem[rf_addr];

  always @(posedge rf_we or posedge do_load) begin
    if (do_load) begin
      for (int i = 0; i < 4; i++) rf_mem[i] = preload_val[i];
    end else begin
      rf_mem[rf_addr] = rf_wdata;
    end
  end

  // Strobe monitor: counts high cycles and records the address seen during
  // the strobe cycle and the cycle before it.
  int         we_hi_total = 0;
  logic [1:0] we_addr = 2'd0;
  logic [1:0] we_prev_addr = 2'd0;
  logic [1:0] prev_addr = 2'd0;
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      we_hi_total  = we_hi_total + 1;
      we_addr      = rf_addr;
      we_prev_addr = prev_addr;
    end
    prev_addr = rf_addr;
  end

  // Scoreboard
  logic [DW+1:0] exp_q[$];
  int            lat_q[$];
  logic [1:0]    dst_exp_q[$];
  bit            wr_q[$];
  logic [DW-1:0] model [4];
  int            we_base = 0;
  int            total = 0;
  int            bad = 0;

  task automatic preload();
    preload_val[0] = 8'h05; preload_val[1] = 8'h0A;
    preload_val[2] = 8'hFF; preload_val[3] = 8'h01;
    for (int i = 0; i < 4; i++) model[i] = preload_val[i];
    do_load = 1'b1;
    #1;
    do_load = 1'b0;
  endtask

  task automatic push_expect(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] src);
    logic [DW:0]   s;
    logic [DW-1:0] d;
    logic          z;
    logic          c;
    c = 1'b0;
    case (op)
      2'd1: begin s = {1'b0, model[dst]} + {1'b0, model[src]}; d = s[DW-1:0]; c = s[DW]; end
      2'd2: begin d = model[dst] - model[src]; c = (model[dst] < model[src]); end
      default: d = model[src];
    endcase
    z = (d == '0);
    if (op != 2'd3) model[dst] = d;
    exp_q.push_back({d, z, c});
    lat_q.push_back(op == 2'd3 ? 2 : (op == 2'd0 ? 4 : 5));
    dst_exp_q.push_back(dst);
    wr_q.push_back(op != 2'd3);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] src,
                       input bit hold, input bit track);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src = src;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    we_base = we_hi_total;
    if (track) push_expect(op, dst, src);
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      cmd_valid = 1'b0;
      {cmd_op, cmd_dst, cmd_src} = 6'($urandom);
    end
  endtask

  task automatic collect(input int stall);
    int            edges;
    int            lat;
    bit            busy_ok;
    bit            stall_ok;
    bit            wr;
    logic [DW+1:0] e;
    logic [1:0]    d;
    edges = 1;
    busy_ok = 1'b1;
    while (resp_valid !== 1'b1 && edges < 20) begin
      if (cmd_ready !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      edges++;
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: queue size=0 required >0");
      return;
    end
    e = exp_q.pop_front(); lat = lat_q.pop_front(); d = dst_exp_q.pop_front(); wr = wr_q.pop_front();
    if (resp_valid !== 1'b1) begin
      bad++;
      $display("FAIL resp_timeout: resp_valid=%b after %0d edges", resp_valid, edges);
      return;
    end
    total++;
    if (edges != lat) begin
      bad++; $display("FAIL latency: got %0d edges required %0d", edges, lat);
    end
    total++;
    if ({resp_data, resp_zero, resp_carry} !== e) begin
      bad++;
      $display("FAIL resp: data=%h zero=%b carry=%b required data=%h zero=%b carry=%b",
               resp_data, resp_zero, resp_carry, e[DW+1:2], e[1], e[0]);
    end
    total++;
    if (!busy_ok) begin
      bad++; $display("FAIL busy_ready: cmd_ready high while busy, required 0");
    end
    total++;
    if ((we_hi_total - we_base) != (wr ? 1 : 0)) begin
      bad++; $display("FAIL we_pulse: %0d strobe cycles required %0d", we_hi_total - we_base, wr ? 1 : 0);
    end
    if (wr) begin
      total++;
      if (we_addr !== d || we_prev_addr !== d || rf_mem[d] !== e[DW+1:2]) begin
        bad++;
        $display("FAIL write: addr=%0d setup_addr=%0d mem=%h required addr=%0d data=%h",
                 we_addr, we_prev_addr, rf_mem[d], d, e[DW+1:2]);
      end
    end
    if (stall > 0) begin
      stall_ok = 1'b1;
      for (int i = 0; i < stall; i++) begin
        if (resp_valid !== 1'b1 || {resp_data, resp_zero, resp_carry} !== e || cmd_ready !== 1'b0)
          stall_ok = 1'b0;
        @(negedge clk);
      end
      total++;
      if (!stall_ok || resp_valid !== 1'b1) begin
        bad++; $display("FAIL stall_hold: response not held for %0d cycles, data=%h", stall, resp_data);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    total++;
    if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL handshake: resp_valid=%b cmd_ready=%b required 0 1", resp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({rf_addr, rf_wdata, rf_we, resp_valid, resp_data, resp_zero, resp_carry} !== '0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: addr=%0d wdata=%h we=%b rv=%b rd=%h z=%b c=%b ready=%b",
               rf_addr, rf_wdata, rf_we, resp_valid, resp_data, resp_zero, resp_carry, cmd_ready);
    end
  endtask

  task automatic test_read();
    issue(2'd3, 2'd0, 2'd1, 1'b0, 1'b1);
    collect(0);
  endtask

  task automatic test_add_wrap();
    issue(2'd1, 2'd2, 2'd3, 1'b0, 1'b1);
    collect(0);
  endtask

  task automatic test_sub();
    issue(2'd2, 2'd0, 2'd1, 1'b0, 1'b1);
    collect(0);
    issue(2'd2, 2'd1, 2'd1, 1'b0, 1'b1);
    collect(0);
  endtask

  task automatic test_back_to_back();
    preload();
    issue(2'd0, 2'd3, 2'd1, 1'b1, 1'b1);
    cmd_op = 2'd3; cmd_dst = 2'd0; cmd_src = 2'd3;
    collect(0);
    issue(2'd3, 2'd0, 2'd3, 1'b0, 1'b1);
    collect(0);
  endtask

  task automatic test_stall();
    issue(2'd1, 2'd0, 2'd1, 1'b0, 1'b1);
    collect(10);
  endtask

  task automatic test_reset_mid_write();
    preload();
    issue(2'd1, 2'd1, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (state_dbg !== ST_WR_SETUP) begin
      bad++; $display("FAIL reach_wr_setup: state=%0d required %0d", state_dbg, ST_WR_SETUP);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({rf_addr, rf_wdata, rf_we, resp_valid, resp_data, resp_zero, resp_carry} !== '0) begin
      bad++;
      $display("FAIL reset_mid_write: addr=%0d wdata=%h we=%b rv=%b rd=%h required all 0",
               rf_addr, rf_wdata, rf_we, resp_valid, resp_data);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL ready_after_rst: cmd_ready=%b required 1", cmd_ready);
    end
    for (int i = 0; i < 5; i++) @(negedge clk);
    total++;
    if (we_hi_total != we_base || resp_valid !== 1'b0 || rf_mem[1] !== 8'h0A) begin
      bad++;
      $display("FAIL abandoned_cmd: strobes=%0d rv=%b R1=%h required 0 0 0a",
               we_hi_total - we_base, resp_valid, rf_mem[1]);
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [1:0] d;
    logic [1:0] s;
    for (int i = 0; i < 20; i++) begin
      op = 2'($urandom_range(0, 3));
      d  = 2'($urandom_range(0, 3));
      s  = 2'($urandom_range(0, 3));
      issue(op, d, s, 1'b0, 1'b1);
      collect($urandom_range(0, 3));
    end
  endtask

  initial begin
    preload();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_read();
    test_add_wrap();
    test_sub();
    test_back_to_back();
    test_stall();
    test_reset_mid_write();
    test_random();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL leftover: %0d expected responses never seen", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
